// File: rtl/rf_pkg.sv
// Shared types and constants for the reg_file write-port arbiter.
package rf_pkg;

  localparam int RF_ADDR_W    = 2;
  localparam int RF_DATA_W    = 8;
  localparam int RF_MAX_BURST = 4;
  localparam int RF_BEAT_W    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_e;

  // True on the final beat a locked owner may take before it must release.
  function automatic logic burst_done(input logic [RF_BEAT_W-1:0] beat);
    return (beat == RF_BEAT_W'(RF_MAX_BURST - 1));
  endfunction

endpackage

// File: rtl/rf_sat_cnt.sv
// Saturating event counter used for per-requester transfer statistics.
module rf_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         areset_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_r;

  // Count up on each event, sticking at all-ones.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != '1)) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/rf_wr_arb.sv
// Two-requester arbiter for the single reg_file write port, with locked bursts.
// Optional transfer counters cnt_a/cnt_b are built when RF_ARB_STATS_EN is defined.
module rf_wr_arb
  import rf_pkg::*;
(
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic                 req_a,
  input  logic                 lock_a,
  input  logic [RF_ADDR_W-1:0] rd_a,
  input  logic [RF_DATA_W-1:0] wdata_a,
  output logic                 gnt_a,
  input  logic                 req_b,
  input  logic                 lock_b,
  input  logic [RF_ADDR_W-1:0] rd_b,
  input  logic [RF_DATA_W-1:0] wdata_b,
  output logic                 gnt_b,
  output logic                 wen,
  output logic [RF_ADDR_W-1:0] rd,
  output logic [RF_DATA_W-1:0] wdata,
  output logic                 busy
`ifdef RF_ARB_STATS_EN
  ,
  output logic [7:0]           cnt_a,
  output logic [7:0]           cnt_b
`endif
);

  arb_state_e           state_r, state_s;
  logic [RF_BEAT_W-1:0] beat_r, beat_s;
  logic                 ptr_b_r, ptr_b_s;
  logic                 seen_r, seen_s;
  logic                 armed_r;
  logic                 wen_r;
  logic [RF_ADDR_W-1:0] rd_r;
  logic [RF_DATA_W-1:0] wdata_r;
  logic                 xfer_a_s, xfer_b_s;
  logic                 tie_b_s;

  assign xfer_a_s = (state_r == OWN_A) && req_a;
  assign xfer_b_s = (state_r == OWN_B) && req_b;
  // ptr_b_r names the last requester to transfer; before any transfer A wins ties.
  assign tie_b_s  = seen_r && !ptr_b_r;

  // Next-state, burst beat count and round-robin pointer.
  always_comb begin
    state_s = state_r;
    beat_s  = beat_r;
    ptr_b_s = ptr_b_r;
    seen_s  = seen_r;
    case (state_r)
      IDLE: begin
        beat_s = '0;
        if (!armed_r) begin
          state_s = IDLE;
        end else if (req_a && req_b) begin
          state_s = tie_b_s ? OWN_B : OWN_A;
        end else if (req_a) begin
          state_s = OWN_A;
        end else if (req_b) begin
          state_s = OWN_B;
        end else begin
          state_s = IDLE;
        end
      end
      OWN_A: begin
        if (req_a) begin
          if (lock_a && !burst_done(beat_r)) begin
            beat_s = beat_r + 2'd1;
          end else if (req_b) begin
            state_s = OWN_B;
            beat_s  = '0;
          end else if (lock_a) begin
            beat_s = '0;
          end else begin
            beat_s = beat_r + 2'd1;
          end
        end else begin
          state_s = req_b ? OWN_B : IDLE;
          beat_s  = '0;
        end
      end
      OWN_B: begin
        if (req_b) begin
          if (lock_b && !burst_done(beat_r)) begin
            beat_s = beat_r + 2'd1;
          end else if (req_a) begin
            state_s = OWN_A;
            beat_s  = '0;
          end else if (lock_b) begin
            beat_s = '0;
          end else begin
            beat_s = beat_r + 2'd1;
          end
        end else begin
          state_s = req_a ? OWN_A : IDLE;
          beat_s  = '0;
        end
      end
      default: begin
        state_s = IDLE;
        beat_s  = '0;
      end
    endcase
    if (xfer_a_s) begin
      ptr_b_s = 1'b0;
      seen_s  = 1'b1;
    end else if (xfer_b_s) begin
      ptr_b_s = 1'b1;
      seen_s  = 1'b1;
    end else begin
      ptr_b_s = ptr_b_r;
      seen_s  = seen_r;
    end
  end

  // Arbiter state; armed_r holds off the first grant for one cycle after reset.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_r <= IDLE;
      beat_r  <= '0;
      ptr_b_r <= 1'b0;
      seen_r  <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      state_r <= state_s;
      beat_r  <= beat_s;
      ptr_b_r <= ptr_b_s;
      seen_r  <= seen_s;
      armed_r <= 1'b1;
    end
  end

  // Write-port register: pulses wen for one cycle per transfer, holds rd/wdata.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      wen_r   <= 1'b0;
      rd_r    <= '0;
      wdata_r <= '0;
    end else if (xfer_a_s) begin
      wen_r   <= 1'b1;
      rd_r    <= rd_a;
      wdata_r <= wdata_a;
    end else if (xfer_b_s) begin
      wen_r   <= 1'b1;
      rd_r    <= rd_b;
      wdata_r <= wdata_b;
    end else begin
      wen_r   <= 1'b0;
      rd_r    <= rd_r;
      wdata_r <= wdata_r;
    end
  end

  assign gnt_a = (state_r == OWN_A);
  assign gnt_b = (state_r == OWN_B);
  assign busy  = (state_r != IDLE);
  assign wen   = wen_r;
  assign rd    = rd_r;
  assign wdata = wdata_r;

`ifdef RF_ARB_STATS_EN
  rf_sat_cnt #(.W(8)) u_cnt_a (
    .clk      (clk),
    .areset_n (areset_n),
    .inc      (xfer_a_s),
    .cnt      (cnt_a)
  );

  rf_sat_cnt #(.W(8)) u_cnt_b (
    .clk      (clk),
    .areset_n (areset_n),
    .inc      (xfer_b_s),
    .cnt      (cnt_b)
  );
`else
  // Statistics disabled: no counters and no cnt_a/cnt_b ports.
`endif

endmodule

// File: tb/tb_rf_wr_arb.sv
// Directed self-checking bench for rf_wr_arb; define RF_ARB_STATS_EN to also check the counters.
module tb_rf_wr_arb;

  logic       clk = 1'b0;
  logic       areset_n;
  logic       req_a, lock_a, req_b, lock_b;
  logic [1:0] rd_a, rd_b, rd;
  logic [7:0] wdata_a, wdata_b, wdata;
  logic       gnt_a, gnt_b, wen, busy;
`ifdef RF_ARB_STATS_EN
  logic [7:0] cnt_a, cnt_b;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rf_wr_arb dut (
    .clk      (clk),
    .areset_n (areset_n),
    .req_a    (req_a),
    .lock_a   (lock_a),
    .rd_a     (rd_a),
    .wdata_a  (wdata_a),
    .gnt_a    (gnt_a),
    .req_b    (req_b),
    .lock_b   (lock_b),
    .rd_b     (rd_b),
    .wdata_b  (wdata_b),
    .gnt_b    (gnt_b),
    .wen      (wen),
    .rd       (rd),
    .wdata    (wdata),
    .busy     (busy)
`ifdef RF_ARB_STATS_EN
    ,
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_a = 1'b0; lock_a = 1'b0; rd_a = 2'd0; wdata_a = 8'h00;
    req_b = 1'b0; lock_b = 1'b0; rd_b = 2'd0; wdata_b = 8'h00;
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    idle_inputs();
    cyc(1);
    areset_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    areset_n = 1'b1;
    idle_inputs();
    #1 areset_n = 1'b0;
    #1;
    check("rst_gnt_a", 32'(gnt_a), 32'd0);
    check("rst_gnt_b", 32'(gnt_b), 32'd0);
    check("rst_wen",   32'(wen),   32'd0);
    check("rst_rd",    32'(rd),    32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    cyc(1);
    areset_n = 1'b1;

    // A only: grant held back one cycle after reset, then a single write of 8'h55 to r2.
    req_a = 1'b1; rd_a = 2'd2; wdata_a = 8'h55;
    cyc(1);
    check("a_only_no_early_gnt", 32'(gnt_a), 32'd0);
    cyc(1);
    check("a_only_gnt",  32'(gnt_a), 32'd1);
    check("a_only_busy", 32'(busy),  32'd1);
    check("a_only_wen0", 32'(wen),   32'd0);
    cyc(1);
    req_a = 1'b0;
    check("a_only_wen",   32'(wen),   32'd1);
    check("a_only_rd",    32'(rd),    32'd2);
    check("a_only_wdata", 32'(wdata), 32'h55);
    cyc(1);
    check("a_only_wen_drop", 32'(wen),   32'd0);
    check("a_only_rd_hold",  32'(rd),    32'd2);
    check("a_only_wd_hold",  32'(wdata), 32'h55);
    check("a_only_idle",     32'(busy),  32'd0);

    // Both requesting, no lock: A first, then strict alternation.
    do_reset();
    req_a = 1'b1; rd_a = 2'd1; wdata_a = 8'hA1;
    req_b = 1'b1; rd_b = 2'd3; wdata_b = 8'hB1;
    cyc(1);
    check("alt_first_gnt_a", 32'(gnt_a), 32'd1);
    check("alt_first_gnt_b", 32'(gnt_b), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check("alt_wen",   32'(wen),   32'd1);
      check("alt_wdata", 32'(wdata), (i % 2 == 0) ? 32'hA1 : 32'hB1);
      check("alt_rd",    32'(rd),    (i % 2 == 0) ? 32'd1 : 32'd3);
      check("alt_gnt_a", 32'(gnt_a), (i % 2 == 0) ? 32'd0 : 32'd1);
    end
    req_a = 1'b0; req_b = 1'b0;
    cyc(1);
    check("alt_end_wen",  32'(wen),  32'd0);
    check("alt_end_busy", 32'(busy), 32'd0);

    // Locked A burst with B waiting: 4 A beats, one B beat, then A resumes.
    do_reset();
    req_a = 1'b1; lock_a = 1'b1; rd_a = 2'd0; wdata_a = 8'h10;
    req_b = 1'b1; rd_b = 2'd3; wdata_b = 8'hBB;
    cyc(1);
    check("lock_gnt_a", 32'(gnt_a), 32'd1);
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      check("lock_a_wdata", 32'(wdata), 32'h10 + 32'(k));
      check("lock_a_rd",    32'(rd),    32'd0);
      check("lock_gnt_b",   32'(gnt_b), (k == 3) ? 32'd1 : 32'd0);
      wdata_a = 8'h11 + 8'(k);
    end
    cyc(1);
    check("lock_b_wdata",  32'(wdata), 32'hBB);
    check("lock_b_wen",    32'(wen),   32'd1);
    check("lock_resume_a", 32'(gnt_a), 32'd1);
    cyc(1);
    check("lock_a5_wdata", 32'(wdata), 32'h14);
    wdata_a = 8'h15;
    cyc(1);
    check("lock_a6_wdata", 32'(wdata), 32'h15);
    check("lock_a6_gnt_a", 32'(gnt_a), 32'd1);
    idle_inputs();
    cyc(1);
    check("lock_end_busy", 32'(busy), 32'd0);

    // B owns, then drops while A requests: ownership moves to A with no B write.
    req_b = 1'b1; rd_b = 2'd2; wdata_b = 8'h77;
    cyc(1);
    check("bdrop_gnt_b", 32'(gnt_b), 32'd1);
    req_b = 1'b0;
    req_a = 1'b1; rd_a = 2'd1; wdata_a = 8'h3C;
    cyc(1);
    check("bdrop_gnt_a", 32'(gnt_a), 32'd1);
    check("bdrop_nogb",  32'(gnt_b), 32'd0);
    check("bdrop_wen",   32'(wen),   32'd0);
    cyc(1);
    check("bdrop_a_wen",   32'(wen),   32'd1);
    check("bdrop_a_wdata", 32'(wdata), 32'h3C);
    idle_inputs();
    cyc(2);

    // Reset mid-burst after the second beat: everything clears, no trailing write, A wins the next tie.
    do_reset();
    req_a = 1'b1; lock_a = 1'b1; rd_a = 2'd3; wdata_a = 8'h21;
    cyc(2);
    wdata_a = 8'h22;
    cyc(1);
    check("mid_beat2_wdata", 32'(wdata), 32'h22);
    #1 areset_n = 1'b0;
    #1;
    check("mid_rst_wen",   32'(wen),   32'd0);
    check("mid_rst_gnt_a", 32'(gnt_a), 32'd0);
    check("mid_rst_busy",  32'(busy),  32'd0);
    check("mid_rst_wdata", 32'(wdata), 32'd0);
    lock_a = 1'b0; req_b = 1'b1; wdata_b = 8'h99;
    cyc(1);
    areset_n = 1'b1;
    cyc(1);
    check("mid_rel_wen",   32'(wen),   32'd0);
    check("mid_rel_gnt_a", 32'(gnt_a), 32'd0);
    cyc(1);
    check("mid_ptr_gnt_a", 32'(gnt_a), 32'd1);
    check("mid_ptr_gnt_b", 32'(gnt_b), 32'd0);
    check("mid_ptr_wen",   32'(wen),   32'd0);
    idle_inputs();
    cyc(2);

`ifdef RF_ARB_STATS_EN
    // 300 back-to-back A transfers saturate cnt_a; cnt_b never moves.
    do_reset();
    req_a = 1'b1; wdata_a = 8'h5A;
    cyc(1);
    cyc(300);
    idle_inputs();
    cyc(2);
    check("stats_cnt_a", 32'(cnt_a), 32'd255);
    check("stats_cnt_b", 32'(cnt_b), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
